// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register sequencer: register mode codes,
// command encodings and the controller state type.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic OP_TX   = 1'b0;
  localparam logic OP_RX   = 1'b1;
  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Client command bus plus shift-register control bundle for usr_seq_ctrl.
// The slave modport is the controller's view; master is the client/register side.
interface usr_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic             cmd_dir;
  logic [CW-1:0]    cmd_len;
  logic [WIDTH-1:0] cmd_data;
  logic             shift_en;
  logic             abort;
  logic             ser_in;
  logic             sr_sout;
  logic [1:0]       sr_mode;
  logic [WIDTH-1:0] sr_pin;
  logic             sr_sin;
  logic             ser_out;
  logic             ser_out_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_len, cmd_data, shift_en, abort, ser_in, sr_sout,
    input  cmd_ready, sr_mode, sr_pin, sr_sin, ser_out, ser_out_valid, busy, done, err, aborted
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_len, cmd_data, shift_en, abort, ser_in, sr_sout,
    output cmd_ready, sr_mode, sr_pin, sr_sin, ser_out, ser_out_valid, busy, done, err, aborted
  );

endinterface

// File: rtl/usr_bit_cnt.sv
// Loadable down-counter for remaining shift bits; saturates at zero and flags a count of one.
module usr_bit_cnt #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          is_one_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == CW'(1));

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register: loads and shifts out a word (transmit)
// or shifts in a word (receive), then pulses done.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(WIDTH + 1),
  parameter logic        FILL  = 1'b0
) (
  input logic          clk,
  input logic          rst,
  usr_seq_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             op_q, dir_q;
  logic [WIDTH-1:0] pin_q;
  logic             done_q, err_q, aborted_q;

  logic             accept;
  logic             abort_take;
  logic [CW-1:0]    len_clamped;
  logic             len_zero;
  logic             cnt_en;
  logic             cnt_is_one;

  assign accept      = bus.cmd_valid && (state_q == StIdle);
  assign len_clamped = (bus.cmd_len > CW'(WIDTH)) ? CW'(WIDTH) : bus.cmd_len;
  assign len_zero    = (len_clamped == '0);
  // Abort only counts while the register is being driven; IDLE/DONE ignore it.
  assign abort_take  = bus.abort && ((state_q == StLoad) || (state_q == StShift));

  usr_bit_cnt #(
    .CW (CW)
  ) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (len_clamped),
    .en_i       (cnt_en),
    .is_one_o   (cnt_is_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (len_zero) begin
            state_d = StDone;
          end else if (bus.cmd_op == OP_TX) begin
            state_d = StLoad;
          end else begin
            state_d = StShift;
          end
        end
      end
      StLoad: begin
        state_d = abort_take ? StIdle : StShift;
      end
      StShift: begin
        if (abort_take) begin
          state_d = StIdle;
        end else if (bus.shift_en && cnt_is_one) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.sr_mode       = MODE_HOLD;
    bus.ser_out_valid = 1'b0;
    cnt_en            = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (!abort_take) begin
          bus.sr_mode = MODE_LOAD;
        end
      end
      StShift: begin
        if (!abort_take && bus.shift_en) begin
          bus.sr_mode       = (dir_q == DIR_MSB) ? MODE_SHL : MODE_SHR;
          bus.ser_out_valid = (op_q == OP_TX);
          cnt_en            = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_TX;
      dir_q     <= DIR_LSB;
      pin_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.cmd_op;
        dir_q <= bus.cmd_dir;
        pin_q <= bus.cmd_data;
      end
      done_q    <= (state_d == StDone);
      err_q     <= accept && len_zero;
      aborted_q <= abort_take;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sr_sin    = (op_q == OP_RX) ? bus.ser_in : FILL;
  assign bus.ser_out   = bus.sr_sout;
  assign bus.sr_pin    = pin_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.aborted   = aborted_q;

endmodule
